mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the IF stage (instruction reads) and the MM stage (lw/sw).
- Sequences each access with a request/ack handshake and latches the winning request.
- Returns read data to the requester that owns the access.
- Drives per-requester stall outputs, which the hazard logic ORs into PC_Write/IFID_Write and the pipeline-register holds.

Parameters:
- ADDR_W, 32, address width of requesters and memory.
- DATA_W, 32, data width of requesters and memory.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- if_req  input  1  IF read request; held high until if_ack.
- if_addr  input  ADDR_W  IF read address.
- if_rdata  output  DATA_W  instruction word; valid while if_ack=1.
- if_ack  output  1  one-cycle completion pulse to IF.
- mm_req  input  1  MM request; held high until mm_ack.
- mm_we  input  1  1 = store (sw), 0 = load (lw).
- mm_addr  input  ADDR_W  MM address.
- mm_wdata  input  DATA_W  store data.
- mm_rdata  output  DATA_W  load data; valid while mm_ack=1 after a load.
- mm_ack  output  1  one-cycle completion pulse to MM.
- mem_req  output  1  memory access strobe; held until mem_ready.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid with mem_ready.
- mem_ready  input  1  memory completion; sampled only while mem_req=1.
- if_stall  output  1  if_req & ~if_ack (combinational).
- mm_stall  output  1  mm_req & ~mm_ack (combinational).

Behaviour:
- States: IDLE, GNT_IF, GNT_MM, RESP.
- Reset:
  - state=IDLE.
  - mem_req, mem_we, if_ack, mm_ack = 0.
  - mem_addr, mem_wdata, if_rdata, mm_rdata = 0.
  - Last-grant register = IF.
- All outputs except the stalls are registered.
- IDLE:
  - mm_req=1 → GNT_MM. Latch mm_addr and mm_wdata; mem_we=mm_we; mem_req=1 next cycle.
  - Else if_req=1 → GNT_IF. Latch if_addr; mem_we=0; mem_wdata=0; mem_req=1.
  - Else stay in IDLE.
  - Fixed priority: MM wins when both request (older instruction first).
- GNT_x:
  - mem_req and the latched mem_* are held stable. Requester input changes are ignored.
  - On mem_ready=1: mem_req←0, mem_we←0, state→RESP, x_ack←1.
  - On a load, x_rdata←mem_rdata.
  - Stores leave mm_rdata unchanged.
- RESP:
  - x_ack is high for exactly this cycle; x_ack←0 and state→IDLE.
  - All requests are ignored in RESP. The requester sees the ack at the edge, so this prevents a stale re-grant.
  - The requester must drop req, or present a new request, by the next IDLE cycle.
- Latency: req seen in IDLE at cycle 0.
  - mem_req high from cycle 1.
  - With mem_ready at cycle k ≥ 1, ack is high in cycle k+1.
  - Minimum 3 cycles per access; back-to-back throughput is 1 access per 3 cycles at zero memory wait.
- mem_ready outside GNT_* is ignored.
- Reset mid-access: the access is aborted, all outputs drop immediately to reset values, and no ack is issued. The memory must tolerate a dropped mem_req.
- Holding rdata: if_rdata/mm_rdata keep their last value after the ack.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both request in IDLE, grant the requester not named in the last-grant register.
  - Last-grant updates on every grant.
  - A single requester is always granted.
- Undefined: fixed MM-over-IF priority; the last-grant register is not built.

Decomposition:
- Shared package (declarations file):
  - State encodings ARB_IDLE, ARB_GNT_IF, ARB_GNT_MM, ARB_RESP (2-bit).
  - Requester ids ARB_ID_IF=1'b0, ARB_ID_MM=1'b1.
- Sub-module arb_pick: combinational 2-way pick.
  - Inputs: if_req, mm_req, last_grant.
  - Outputs: grant_valid, grant_id.
  - Compiles to fixed priority or round-robin under MEM_ARB_RR_EN.

Test Plan:
- Reset: assert rst_n=0 mid-GNT_MM with mem_req=1 → mem_req=0 and mm_ack=0 immediately; after release, state IDLE and all outputs 0.
- IF read: if_req=1, if_addr=0x0000_0040; mem_ready at first GNT cycle with mem_rdata=0x2008_0005 → mem_addr=0x40, mem_we=0 at cycle 1; if_ack=1 and if_rdata=0x2008_0005 at cycle 2; if_stall=1 in cycles 0–1, 0 in cycle 2.
- MM store with wait: mm_req=1, mm_we=1, mm_addr=0x100, mm_wdata=0xDEAD_BEEF; mem_ready after 3 wait cycles → mem_we=1, mem_wdata=0xDEAD_BEEF stable for 4 cycles; single mm_ack pulse; mm_rdata unchanged.
- Contention: if_req=mm_req=1 in the same IDLE cycle (mm load 0x200→0x1234) → MM granted first; IF granted in the IDLE cycle after RESP; exactly one ack each; if_stall held throughout the MM access.
- No stale re-grant: hold mm_req=1 through RESP with a new mm_addr=0x204 → the second access starts only from IDLE and uses 0x204; mem_ready pulses outside GNT are ignored.
- MEM_ARB_RR_EN: both requesters held high continuously → grants alternate MM, IF, MM, IF (last-grant=IF at reset); without the macro → MM granted every time.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared state encodings and requester ids for mem_port_arbiter (build option MEM_ARB_RR_EN)
package mem_port_arbiter_pkg;

    // Arbiter FSM encodings
    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_GNT_IF = 2'd1;
    localparam logic [1:0] ARB_GNT_MM = 2'd2;
    localparam logic [1:0] ARB_RESP   = 2'd3;

    // Requester identifiers, also the encoding of the last-grant register
    localparam logic ARB_ID_IF = 1'b0;
    localparam logic ARB_ID_MM = 1'b1;

    // The requester that is not the given one
    function automatic logic arb_other(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// rtl/mem_port_arbiter_arb_pick.sv - combinational 2-way requester pick; round-robin when MEM_ARB_RR_EN is defined
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic i_if_req,
    input  logic i_mm_req,
    input  logic i_last_grant,
    output logic o_grant_valid,
    output logic o_grant_id
);

`ifndef MEM_ARB_RR_EN
    // Fixed priority never looks at history
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
`endif

    // Choose which requester wins this IDLE cycle
    always_comb begin
        o_grant_valid = i_if_req | i_mm_req;
        o_grant_id    = ARB_ID_MM;
`ifdef MEM_ARB_RR_EN
        if (i_if_req && i_mm_req) begin
            o_grant_id = arb_other(i_last_grant);
        end else if (i_if_req) begin
            o_grant_id = ARB_ID_IF;
        end
`else
        // MM holds the older instruction, so it goes first
        if (!i_mm_req) begin
            o_grant_id = ARB_ID_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MM arbiter for one single-ported variable-latency memory (build option MEM_ARB_RR_EN)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ack,
    input  logic              i_mm_req,
    input  logic              i_mm_we,
    input  logic [ADDR_W-1:0] i_mm_addr,
    input  logic [DATA_W-1:0] i_mm_wdata,
    output logic [DATA_W-1:0] o_mm_rdata,
    output logic              o_mm_ack,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_if_stall,
    output logic              o_mm_stall
);

    logic [1:0]        r_state;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mm_rdata;
    logic              r_if_ack;
    logic              r_mm_ack;

    logic              w_last_grant;
    logic              w_grant_valid;
    logic              w_grant_id;

    arb_pick u_arb_pick (
        .i_if_req      (i_if_req),
        .i_mm_req      (i_mm_req),
        .i_last_grant  (w_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

`ifdef MEM_ARB_RR_EN
    logic r_last_grant;

    // Remember who was served last so a tie goes to the other requester
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= ARB_ID_IF;
        end else if (r_state == ARB_IDLE && w_grant_valid) begin
            r_last_grant <= w_grant_id;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = ARB_ID_IF;
`endif

    // Access sequencer: latch winner in IDLE, hold until mem_ready, ack for one RESP cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ARB_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_mm_rdata  <= '0;
            r_if_ack    <= 1'b0;
            r_mm_ack    <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_valid) begin
                        r_mem_req <= 1'b1;
                        if (w_grant_id == ARB_ID_MM) begin
                            r_state     <= ARB_GNT_MM;
                            r_mem_we    <= i_mm_we;
                            r_mem_addr  <= i_mm_addr;
                            r_mem_wdata <= i_mm_wdata;
                        end else begin
                            r_state     <= ARB_GNT_IF;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= i_if_addr;
                            r_mem_wdata <= '0;
                        end
                    end
                end
                ARB_GNT_IF: begin
                    if (i_mem_ready) begin
                        r_state    <= ARB_RESP;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_if_ack   <= 1'b1;
                        r_if_rdata <= i_mem_rdata;
                    end
                end
                ARB_GNT_MM: begin
                    if (i_mem_ready) begin
                        r_state   <= ARB_RESP;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mm_ack  <= 1'b1;
                        // A store returns nothing, so the last load value stays visible
                        if (!r_mem_we) begin
                            r_mm_rdata <= i_mem_rdata;
                        end
                    end
                end
                default: begin
                    // Requests are ignored here: the requester only sees the ack after this edge
                    r_state  <= ARB_IDLE;
                    r_if_ack <= 1'b0;
                    r_mm_ack <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_mm_rdata  = r_mm_rdata;
    assign o_if_ack    = r_if_ack;
    assign o_mm_ack    = r_mm_ack;

    assign o_if_stall  = i_if_req & ~r_if_ack;
    assign o_mm_stall  = i_mm_req & ~r_mm_ack;

endmodule
